// File: rtl/bnn_pkg.sv
// Shared constants and types for the binarized MNIST network layers.
package bnn_pkg;

  localparam int unsigned IMG_DIM   = 28;
  localparam int unsigned POOL_DIM  = 14;
  localparam int unsigned N_FILT    = 8;
  localparam int unsigned K_DIM     = 3;
  localparam int unsigned L1_THRESH = 5;

  localparam logic [2:0] ST_LAYER_ONE = 3'd1;

  typedef logic [IMG_DIM-1:0]                 img_row_t;
  typedef img_row_t                           img_t [IMG_DIM-1:0];
  typedef logic [K_DIM-1:0][K_DIM-1:0]        kernel_t;
  typedef logic [POOL_DIM-1:0][POOL_DIM-1:0]  map_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } l1_state_e;

endpackage

// File: rtl/bnn_xnor_pop9.sv
// One binary 3x3 convolution site: XNOR the window against the kernel,
// count agreements and compare against the threshold.
module bnn_xnor_pop9
  import bnn_pkg::*;
#(
  parameter int unsigned Thresh = L1_THRESH
) (
  input  logic [8:0] window_i,
  input  logic [8:0] kernel_i,
  output logic       match_o
);

  logic [8:0] agree;
  logic [3:0] count;

  always_comb begin
    agree = ~(window_i ^ kernel_i);
    count = '0;
    for (int i = 0; i < 9; i++) begin
      count = count + {3'b000, agree[i]};
    end
    match_o = (count >= 4'(Thresh));
  end

endmodule

// File: rtl/bnn_layer_one.sv
// Layer one: same-padded binary 3x3 conv for 8 filters, threshold, then 2x2 OR-pooling.
// One pooled position (4 conv sites x 8 filters) is produced per cycle.
module bnn_layer_one
  import bnn_pkg::*;
#(
  parameter int unsigned THRESH    = L1_THRESH,
  parameter logic [2:0]  RUN_STATE = ST_LAYER_ONE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  img_t       pixels,
  input  kernel_t    weights       [N_FILT-1:0],
  output map_t       layer_one_out [N_FILT-1:0],
  output logic       done
);

  localparam logic [3:0] LastPos = 4'(POOL_DIM - 1);

  l1_state_e  st_q, st_d;
  logic [3:0] pr_q, pr_d;
  logic [3:0] pc_q, pc_d;
  logic       done_q, done_d;
  map_t       out_q [N_FILT-1:0];
  map_t       out_d [N_FILT-1:0];

  // Site s covers conv pixel (2*pr + s/2, 2*pc + s%2); window bit k is kernel tap (k/3, k%3).
  logic [8:0] win [4];

  always_comb begin
    int yy;
    int xx;
    for (int s = 0; s < 4; s++) begin
      win[s] = '0;
      for (int k = 0; k < 9; k++) begin
        yy = 2 * int'(pr_q) + s / 2 + k / 3 - 1;
        xx = 2 * int'(pc_q) + s % 2 + k % 3 - 1;
        if (yy >= 0 && yy < int'(IMG_DIM) && xx >= 0 && xx < int'(IMG_DIM)) begin
          win[s][k] = pixels[yy[4:0]][xx[4:0]];
        end
      end
    end
  end

  logic [4*N_FILT-1:0] hit;

  for (genvar f = 0; f < N_FILT; f++) begin : g_filt
    for (genvar s = 0; s < 4; s++) begin : g_site
      bnn_xnor_pop9 #(
        .Thresh (THRESH)
      ) u_pop (
        .window_i (win[s]),
        .kernel_i (weights[f]),
        .match_o  (hit[f*4+s])
      );
    end
  end

  always_comb begin
    st_d   = st_q;
    pr_d   = pr_q;
    pc_d   = pc_q;
    done_d = done_q;
    out_d  = out_q;
    unique case (st_q)
      StIdle: begin
        done_d = 1'b0;
        if (state == RUN_STATE) begin
          st_d = StRun;
          pr_d = '0;
          pc_d = '0;
          for (int f = 0; f < N_FILT; f++) begin
            out_d[f] = '0;
          end
        end
      end
      StRun: begin
        if (state != RUN_STATE) begin
          st_d = StIdle;
        end else begin
          for (int f = 0; f < N_FILT; f++) begin
            out_d[f][pr_q][pc_q] = |hit[f*4 +: 4];
          end
          if (pc_q == LastPos) begin
            pc_d = '0;
            if (pr_q == LastPos) begin
              st_d   = StDone;
              done_d = 1'b1;
            end else begin
              pr_d = pr_q + 4'd1;
            end
          end else begin
            pc_d = pc_q + 4'd1;
          end
        end
      end
      StDone: begin
        if (state != RUN_STATE) begin
          st_d   = StIdle;
          done_d = 1'b0;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= StIdle;
      pr_q   <= '0;
      pc_q   <= '0;
      done_q <= 1'b0;
      for (int f = 0; f < N_FILT; f++) begin
        out_q[f] <= '0;
      end
    end else begin
      st_q   <= st_d;
      pr_q   <= pr_d;
      pc_q   <= pc_d;
      done_q <= done_d;
      out_q  <= out_d;
    end
  end

  assign layer_one_out = out_q;
  assign done          = done_q;

endmodule

// File: tb/tb_bnn_layer_one.sv
// Scoreboard bench for bnn_layer_one: each run pushes a reference result; a monitor
// compares maps and latency when done rises.
module tb_bnn_layer_one;
  import bnn_pkg::*;

  typedef map_t [N_FILT-1:0] maps_t;
  typedef struct {
    maps_t       maps;
    int unsigned cyc;
  } item_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] state = 3'd0;
  img_t       pixels;
  kernel_t    weights       [N_FILT-1:0];
  map_t       layer_one_out [N_FILT-1:0];
  logic       done;

  int unsigned cyc      = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  item_t       exp_q[$];

  bnn_layer_one #(
    .THRESH    (5),
    .RUN_STATE (3'd1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .state         (state),
    .pixels        (pixels),
    .weights       (weights),
    .layer_one_out (layer_one_out),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [195:0] got, input logic [195:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic maps_t cur_maps();
    maps_t m;
    for (int f = 0; f < N_FILT; f++) m[f] = layer_one_out[f];
    return m;
  endfunction

  task automatic check_maps(input string name, input maps_t want);
    maps_t got;
    got = cur_maps();
    for (int f = 0; f < N_FILT; f++) chk($sformatf("%s_f%0d", name, f), got[f], want[f]);
  endtask

  // Reference: full 28x28 conv per filter with zero padding, then 2x2 OR pooling.
  function automatic maps_t model();
    maps_t m;
    bit    conv [N_FILT][IMG_DIM][IMG_DIM];
    int    cnt, yy, xx;
    bit    p;
    for (int f = 0; f < N_FILT; f++)
      for (int y = 0; y < IMG_DIM; y++)
        for (int x = 0; x < IMG_DIM; x++) begin
          cnt = 0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
              yy = y + r - 1;
              xx = x + c - 1;
              p = (yy >= 0 && yy < 28 && xx >= 0 && xx < 28) ? pixels[yy][xx] : 1'b0;
              if (weights[f][r][c] == p) cnt++;
            end
          conv[f][y][x] = (cnt >= 5);
        end
    m = '0;
    for (int f = 0; f < N_FILT; f++)
      for (int pr = 0; pr < POOL_DIM; pr++)
        for (int pc = 0; pc < POOL_DIM; pc++)
          m[f][pr][pc] = conv[f][2*pr][2*pc] | conv[f][2*pr][2*pc+1] |
                         conv[f][2*pr+1][2*pc] | conv[f][2*pr+1][2*pc+1];
    return m;
  endfunction

  task automatic rand_stim();
    int dens;
    dens = $urandom_range(1, 3);
    for (int i = 0; i < IMG_DIM; i++)
      for (int j = 0; j < IMG_DIM; j++) pixels[i][j] = ($urandom_range(0, 3) < dens);
    for (int f = 0; f < N_FILT; f++) weights[f] = kernel_t'($urandom_range(0, 511));
  endtask

  // Called at a negedge with the DUT idle.
  task automatic do_run(input string name);
    item_t it;
    int    k;
    it.maps = model();
    it.cyc  = cyc + 197;
    exp_q.push_back(it);
    state = 3'd1;
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done_seen"}, done, 1'b1);
    repeat (3) @(negedge clk);
    chk({name, "_done_hold"}, done, 1'b1);
    check_maps({name, "_held"}, it.maps);
    state = 3'd0;
    @(posedge clk);
    #1;
    chk({name, "_done_clear"}, done, 1'b0);
    check_maps({name, "_retain"}, it.maps);
    @(negedge clk);
  endtask

  initial begin : monitor
    item_t it;
    logic  done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          it = exp_q.pop_front();
          chk("done_latency", cyc, it.cyc);
          check_maps("sb_maps", it.maps);
        end
      end
      done_prev = done;
    end
  end

  initial begin : stim
    maps_t zero;
    maps_t full;
    maps_t part;
    zero = '0;
    for (int i = 0; i < IMG_DIM; i++) pixels[i] = '0;
    for (int f = 0; f < N_FILT; f++) weights[f] = '0;

    #3;
    chk("reset_done", done, 1'b0);
    check_maps("reset_out", zero);
    #4 rst_n = 1'b1;
    @(negedge clk);

    repeat (20) @(negedge clk);
    chk("idle_done", done, 1'b0);
    check_maps("idle_out", zero);

    do_run("t1_zero");

    for (int i = 0; i < IMG_DIM; i++) pixels[i] = '1;
    do_run("t2_ones_w0");

    weights[0] = '1;
    do_run("t3_f0_ones");

    // Abort after 50 sampled cycles: edge 0 starts, edges 1..49 write positions 0..48.
    rand_stim();
    full  = model();
    state = 3'd1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    state = 3'd0;
    repeat (5) @(negedge clk);
    chk("abort_done", done, 1'b0);
    part = '0;
    for (int f = 0; f < N_FILT; f++)
      for (int pr = 0; pr < POOL_DIM; pr++)
        for (int pc = 0; pc < POOL_DIM; pc++)
          if (pr * 14 + pc < 49) part[f][pr][pc] = full[f][pr][pc];
    check_maps("abort_partial", part);
    do_run("t5_rerun");

    for (int i = 0; i < IMG_DIM; i++) pixels[i] = '0;
    pixels[10][10] = 1'b1;
    for (int f = 0; f < N_FILT; f++) weights[f] = '1;
    do_run("t4_single");

    // Asynchronous reset mid-run, asserted away from any clock edge.
    rand_stim();
    state = 3'd1;
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_done", done, 1'b0);
    check_maps("async_rst_out", zero);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_run("t6_after_rst");

    for (int n = 0; n < 4; n++) begin
      rand_stim();
      do_run($sformatf("rand%0d", n));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
